// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are gfedcba, active-low.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'b0111111;

    // Index n holds the pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Index of the most significant non-zero nibble among the low n nibbles; 0 when all are zero.
    function automatic logic [2:0] hi_nibble(input logic [31:0] v, input int n);
        logic [2:0] h;
        h = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < n && v[4*i +: 4] != 4'h0) begin
                h = 3'(i);
            end else begin
                h = h;
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg_t       o_seg
);

    assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-wide seven-segment driver with frame-coherent display data.
// Optional brightness PWM: define SEG7_BRIGHTNESS_EN to add the i_bright input.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int TICK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp_mask,
    input  logic                  i_ovf,
    input  logic                  i_blank_lz,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]            i_bright,
`endif
    output logic [6:0]            o_seg_n,
    output logic                  o_dp_n,
    output logic [DIGITS-1:0]     o_an_n,
    output logic                  o_frame
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    logic [DW-1:0]         r_div;
    logic                  r_tick;
    logic                  r_run;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_pend_value;
    logic [DIGITS-1:0]     r_pend_dp;
    logic                  r_pend_ovf;
    logic                  r_pend_valid;
    logic [4*DIGITS-1:0]   r_disp_value;
    logic [DIGITS-1:0]     r_disp_dp;
    logic                  r_disp_ovf;
    logic                  r_disp_blz;

    logic                  w_boundary;
    logic [3:0]            w_nib;
    seg_t                  w_hex;
    logic [2:0]            w_hi;
    seg_t                  w_seg;
    logic                  w_dp;
    logic                  w_pwm_on;
    logic                  w_dark;

`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]            r_pwm;
    logic [3:0]            r_disp_bright;

    // Free-running PWM phase counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
        end
    end
`endif

    // The first tick after reset only starts the scan on digit 0 and counts as a frame boundary.
    assign w_boundary = r_tick && (!r_run || r_idx == IW'(DIGITS - 1));

    // Slot divider; the terminal count is registered so the tick lands TICK_DIV cycles after reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == DW'(TICK_DIV - 1));
            r_div  <= (r_div == DW'(TICK_DIV - 1)) ? '0 : r_div + DW'(1);
        end
    end

    // Digit index and scan-running flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_run <= 1'b0;
            r_idx <= '0;
        end else if (r_tick && !r_run) begin
            r_run <= 1'b1;
        end else if (r_tick) begin
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end
    end

    // Pending capture and frame-boundary copy into the display register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_ovf   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_ovf   <= 1'b0;
            r_disp_blz   <= 1'b0;
            o_frame      <= 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
            r_disp_bright <= 4'd0;
`endif
        end else begin
            o_frame <= w_boundary && r_pend_valid;
            if (w_boundary && r_pend_valid) begin
                r_disp_value <= r_pend_value;
                r_disp_dp    <= r_pend_dp;
                r_disp_ovf   <= r_pend_ovf;
                r_disp_blz   <= i_blank_lz;
`ifdef SEG7_BRIGHTNESS_EN
                r_disp_bright <= i_bright;
`endif
            end
            // A load on the boundary cycle keeps valid set and waits for the next frame.
            if (i_load) begin
                r_pend_value <= i_value;
                r_pend_dp    <= i_dp_mask;
                r_pend_ovf   <= i_ovf;
                r_pend_valid <= 1'b1;
            end else if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign w_nib = r_disp_value[4*int'(r_idx) +: 4];

    seg7_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_hex)
    );

    // Segment source selection for the current digit.
    always_comb begin
        w_hi = hi_nibble(32'(r_disp_value), DIGITS);
        w_dp = r_disp_dp[r_idx];
        if (r_disp_ovf) begin
            w_seg = SEG_DASH;
            w_dp  = 1'b0;
        end else if (r_disp_blz && int'(r_idx) > int'(w_hi)) begin
            w_seg = SEG_BLANK;
        end else begin
            w_seg = w_hex;
        end
`ifdef SEG7_BRIGHTNESS_EN
        w_pwm_on = (r_pwm <= r_disp_bright);
`else
        w_pwm_on = 1'b1;
`endif
        w_dark = r_tick || !r_run;
    end

    // Registered pin drivers; the tick cycle produces the anode dead-time.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            o_seg_n <= SEG_BLANK;
            o_dp_n  <= 1'b1;
            o_an_n  <= '1;
        end else if (w_dark) begin
            o_seg_n <= SEG_BLANK;
            o_dp_n  <= 1'b1;
            o_an_n  <= '1;
        end else begin
            o_seg_n <= w_seg;
            o_dp_n  <= ~w_dp;
            o_an_n  <= w_pwm_on ? ~(DIGITS'(1) << r_idx) : '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver (DIGITS=4, TICK_DIV=4) against a cycle-timeline model.
module tb_seg7_scan_driver;

    localparam int D    = 4;
    localparam int TD   = 4;
    localparam int FR   = D * TD;
    localparam int MAXC = 1200;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic        ovf = 1'b0;
    logic        blz = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  bright = 4'hF;
`endif

    int errors = 0;
    int checks = 0;

    logic        load_h [MAXC];
    logic [15:0] val_h  [MAXC];
    logic [3:0]  dp_h   [MAXC];
    logic        ovf_h  [MAXC];
    logic        blz_h  [MAXC];

    logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(D), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .clr        (clr),
        .i_load     (load),
        .i_value    (value),
        .i_dp_mask  (dp_mask),
        .i_ovf      (ovf),
        .i_blank_lz (blz),
`ifdef SEG7_BRIGHTNESS_EN
        .i_bright   (bright),
`endif
        .o_seg_n    (seg_n),
        .o_dp_n     (dp_n),
        .o_an_n     (an_n),
        .o_frame    (frame)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First frame boundary at or after which a load made at cycle l becomes visible.
    function automatic int copy_bnd(input int l);
        if (l < TD) return TD;
        return TD + ((l - TD) / FR + 1) * FR;
    endfunction

    function automatic int last_load(input int b);
        for (int i = b - 1; i >= 0; i--) begin
            if (load_h[i]) return i;
        end
        return -1;
    endfunction

    // Expected pins during cycle c (cycle 0 = the cycle clr falls).
    task automatic expect_out(input int c, output logic [3:0] e_an, output logic [6:0] e_seg,
                              output logic e_dp, output logic e_frame);
        int u, ph, slot, dg, f, l, hi;
        logic [15:0] v;
        logic [3:0]  dm;
        logic        ov, bz;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
        if (c - 1 >= TD && (c - 1 - TD) % FR == 0) begin
            for (int i = (c - 1 == TD) ? 0 : c - 1 - FR; i < c - 1; i++) begin
                if (load_h[i]) e_frame = 1'b1;
            end
        end
        slot = -1;
        if (c >= TD) begin
            u  = c - TD;
            ph = u % TD;
            slot = (ph == 0) ? u / TD - 1 : ((ph == 1) ? -1 : u / TD);
        end
        if (slot >= 0) begin
            dg = slot % D;
            f  = slot / D;
            l  = last_load(TD + f * FR);
            if (l < 0) begin
                v = 16'h0; dm = 4'h0; ov = 1'b0; bz = 1'b0;
            end else begin
                v = val_h[l]; dm = dp_h[l]; ov = ovf_h[l]; bz = blz_h[copy_bnd(l)];
            end
            hi = 0;
            for (int k = 0; k < D; k++) begin
                if (((v >> (4 * k)) & 16'hF) != 16'h0) hi = k;
            end
            e_an = ~(4'b0001 << dg);
            if (ov) begin
                e_seg = 7'b0111111;
                e_dp  = 1'b1;
            end else begin
                e_seg = (bz && dg > hi) ? 7'h7F : hex_tab[(v >> (4 * dg)) & 16'hF];
                e_dp  = ~dm[dg];
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dm, input logic ov, input logic bz);
        load = 1'b1; value = v; dp_mask = dm; ovf = ov; blz = bz;
    endtask

    task automatic run_epoch(input int n, input bit scripted);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_frame;
        for (int i = 0; i < MAXC; i++) load_h[i] = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            clr  = 1'b0;
            load = 1'b0;
            if (scripted && c < 230) begin
                case (c)
                    2:       do_load(16'h1A3F, 4'h0, 1'b0, 1'b0);
                    40:      do_load(16'h0050, 4'h0, 1'b0, 1'b1);
                    75:      do_load(16'h0000, 4'h0, 1'b0, 1'b1);
                    110:     do_load(16'h1234, 4'hF, 1'b1, 1'b0);
                    140:     do_load(16'h1A3F, 4'b0101, 1'b0, 1'b0);
                    150:     do_load(16'h1111, 4'h0, 1'b0, 1'b0);
                    152:     do_load(16'h2222, 4'h0, 1'b0, 1'b0);
                    196:     do_load(16'h0ABC, 4'b1000, 1'b0, 1'b1);
                    default: load = 1'b0;
                endcase
            end else if (c > 5) begin
                if ($urandom_range(0, 9) == 0) blz = 1'($urandom);
                if ($urandom_range(0, 15) == 0) begin
                    do_load(16'($urandom), 4'($urandom), $urandom_range(0, 7) == 0, 1'($urandom));
                end
            end
            load_h[c] = load; val_h[c] = value; dp_h[c] = dp_mask;
            ovf_h[c] = ovf; blz_h[c] = blz;
            @(negedge clk);
            expect_out(c, e_an, e_seg, e_dp, e_frame);
            check_val($sformatf("an_n c=%0d", c), 32'(an_n), 32'(e_an));
            check_val($sformatf("frame c=%0d", c), 32'(frame), 32'(e_frame));
            if (e_an != 4'hF) begin
                check_val($sformatf("seg_n c=%0d", c), 32'(seg_n), 32'(e_seg));
                check_val($sformatf("dp_n c=%0d", c), 32'(dp_n), 32'(e_dp));
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst seg_n", 32'(seg_n), 32'h7F);
        check_val("rst dp_n", 32'(dp_n), 32'h1);
        check_val("rst an_n", 32'(an_n), 32'hF);
        check_val("rst frame", 32'(frame), 32'h0);

        run_epoch(762, 1'b1);

        @(posedge clk);
        #1;
        clr  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        check_val("clr seg_n", 32'(seg_n), 32'h7F);
        check_val("clr dp_n", 32'(dp_n), 32'h1);
        check_val("clr an_n", 32'(an_n), 32'hF);
        check_val("clr frame", 32'(frame), 32'h0);

        run_epoch(300, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
